pixel_reassembler: RTL

//   Receive-side counterpart of the camera transmit path. Consumes the 2-bit

---
 rtl/pixel_reassembler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pixel_reassembler.sv
// Receive-side pixel reassembler: packs LSB-first dibits into 16-bit words,
// treats the first word of each packet as a start address and writes RGB565 pixels to BRAM.
module pixel_reassembler #(
  parameter int FRAME_PIXELS = 76800,
  parameter int ADDR_WIDTH   = 17
) (
  input  logic                  clk_50mhz,
  input  logic                  rst,
  input  logic                  axiiv,
  input  logic [1:0]            axiid,
  output logic                  pix_we,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  output logic [15:0]           pix_data,
  output logic                  frame_done,
  output logic [15:0]           pkt_count,
  output logic [15:0]           err_count,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

  state_t                state, state_n;
  logic                  axiiv_q;
  logic [2:0]            cnt, cnt_n;
  logic [15:0]           acc, acc_n, acc_ins;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [ADDR_WIDTH-1:0] waddr_n;
  logic [15:0]           data_n;
  logic                  we_n, fd_n;
  logic                  pkt_inc, err_inc;
  logic [31:0]           hdr_val;

  assign fsm_state = state;

  always_comb begin
    acc_ins = acc;
    acc_ins[2*cnt +: 2] = axiid;
    hdr_val = {16'd0, acc_ins};

    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    addr_n  = addr;
    waddr_n = pix_addr;
    data_n  = pix_data;
    we_n    = 1'b0;
    fd_n    = 1'b0;
    pkt_inc = 1'b0;
    err_inc = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = 3'd0;
        // Only a rising edge of axiiv starts a packet; axiiv_q resets high so
        // a packet already in flight at reset is never picked up mid-stream.
        if (axiiv && !axiiv_q) begin
          acc_n   = {14'd0, axiid};
          cnt_n   = 3'd1;
          state_n = HEADER;
        end
      end
      HEADER: begin
        if (!axiiv) begin
          err_inc = 1'b1;
          cnt_n   = 3'd0;
          state_n = IDLE;
        end else begin
          acc_n = acc_ins;
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (hdr_val < FRAME_PIXELS) begin
              addr_n  = hdr_val[ADDR_WIDTH-1:0];
              state_n = PAYLOAD;
            end else begin
              err_inc = 1'b1;
              state_n = DROP;
            end
          end
        end
      end
      PAYLOAD: begin
        if (!axiiv) begin
          // A nonzero dibit count means a partial word: it is discarded.
          if (cnt == 3'd0) pkt_inc = 1'b1;
          else             err_inc = 1'b1;
          cnt_n   = 3'd0;
          state_n = IDLE;
        end else begin
          acc_n = acc_ins;
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            we_n    = 1'b1;
            waddr_n = addr;
            data_n  = acc_ins;
            fd_n    = (addr == LAST_ADDR);
            addr_n  = (addr == LAST_ADDR) ? '0 : addr + ADDR_WIDTH'(1);
          end
        end
      end
      DROP: begin
        cnt_n = 3'd0;
        if (!axiiv) state_n = IDLE;
      end
      default: begin
        cnt_n   = 3'd0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state <= IDLE;
      axiiv_q    <= 1'b1;
      cnt        <= 3'd0;
      acc        <= 16'd0;
      addr       <= '0;
      pix_we     <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= 16'd0;
      frame_done <= 1'b0;
      pkt_count  <= 16'd0;
      err_count  <= 16'd0;
    end else begin
      state      <= state_n;
      axiiv_q    <= axiiv;
      cnt        <= cnt_n;
      acc        <= acc_n;
      addr       <= addr_n;
      pix_we     <= we_n;
      pix_addr   <= waddr_n;
      pix_data   <= data_n;
      frame_done <= fd_n;
      if (pkt_inc && (pkt_count != 16'hFFFF)) pkt_count <= pkt_count + 16'd1;
      if (err_inc && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

endmodule
